// File: rtl/trafficlight_ctrl.sv
// Two-direction intersection controller: one interlocked phase machine drives both
// signal heads, with optional protected-left phases, all-red clearance and emergency all-stop.
module trafficlight_ctrl #(
    parameter int LEFT_CYC   = 5,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int CLEAR_CYC  = 1,
    parameter int LEFT_EN    = 1,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       emergency,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic [3:0] phase,
    output logic       allstop
);

    localparam logic [3:0] S_NS_LEFT   = 4'd0;
    localparam logic [3:0] S_NS_GREEN  = 4'd1;
    localparam logic [3:0] S_NS_YELLOW = 4'd2;
    localparam logic [3:0] S_CLEAR_A   = 4'd3;
    localparam logic [3:0] S_EW_LEFT   = 4'd4;
    localparam logic [3:0] S_EW_GREEN  = 4'd5;
    localparam logic [3:0] S_EW_YELLOW = 4'd6;
    localparam logic [3:0] S_CLEAR_B   = 4'd7;
    localparam logic [3:0] S_ALLSTOP   = 4'd8;
    localparam logic [3:0] S_EMG_CLEAR = 4'd9;

    localparam logic [3:0] S_NS_FIRST = (LEFT_EN != 0) ? S_NS_LEFT : S_NS_GREEN;
    localparam logic [3:0] S_EW_FIRST = (LEFT_EN != 0) ? S_EW_LEFT : S_EW_GREEN;

    localparam logic [3:0] LAMP_LEFT   = 4'b1001;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_RED    = 4'b0001;
    localparam logic [3:0] LAMP_NS_RST = (LEFT_EN != 0) ? LAMP_LEFT : LAMP_GREEN;

    logic [3:0]       state_q, state_d;
    logic [3:0]       saved_q, saved_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ns_d, ew_d;
    logic             allstop_d;

    function automatic logic [3:0] next_phase(input logic [3:0] s);
        case (s)
            S_NS_LEFT:   next_phase = S_NS_GREEN;
            S_NS_GREEN:  next_phase = S_NS_YELLOW;
            S_NS_YELLOW: next_phase = S_CLEAR_A;
            S_CLEAR_A:   next_phase = S_EW_FIRST;
            S_EW_LEFT:   next_phase = S_EW_GREEN;
            S_EW_GREEN:  next_phase = S_EW_YELLOW;
            S_EW_YELLOW: next_phase = S_CLEAR_B;
            S_CLEAR_B:   next_phase = S_NS_FIRST;
            default:     next_phase = S_ALLSTOP;
        endcase
    endfunction

    // Yellow is never re-lit after all-red: an interrupted yellow resumes at its clearance.
    function automatic logic [3:0] resume_phase(input logic [3:0] s);
        case (s)
            S_NS_LEFT, S_NS_GREEN, S_EW_LEFT, S_EW_GREEN: resume_phase = s;
            S_NS_YELLOW: resume_phase = S_CLEAR_A;
            S_EW_YELLOW: resume_phase = S_CLEAR_B;
            S_CLEAR_A:   resume_phase = S_EW_FIRST;
            S_CLEAR_B:   resume_phase = S_NS_FIRST;
            default:     resume_phase = S_NS_FIRST;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] last_cnt(input logic [3:0] s);
        case (s)
            S_NS_LEFT, S_EW_LEFT:                last_cnt = CNT_W'(LEFT_CYC - 1);
            S_NS_GREEN, S_EW_GREEN:              last_cnt = CNT_W'(GREEN_CYC - 1);
            S_NS_YELLOW, S_EW_YELLOW:            last_cnt = CNT_W'(YELLOW_CYC - 1);
            S_CLEAR_A, S_CLEAR_B, S_EMG_CLEAR:   last_cnt = CNT_W'(CLEAR_CYC - 1);
            default:                             last_cnt = '0;
        endcase
    endfunction

    // Phase sequencing, emergency capture and resume selection.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        if (state_q > S_EMG_CLEAR) begin
            state_d = S_ALLSTOP;
            saved_d = S_CLEAR_B;
            cnt_d   = '0;
        end else if (emergency && (state_q != S_ALLSTOP)) begin
            state_d = S_ALLSTOP;
            cnt_d   = '0;
            if (state_q != S_EMG_CLEAR) begin
                saved_d = state_q;
            end else begin
                saved_d = saved_q;
            end
        end else if (state_q == S_ALLSTOP) begin
            cnt_d = '0;
            if (!emergency) begin
                state_d = S_EMG_CLEAR;
            end else begin
                state_d = S_ALLSTOP;
            end
        end else if (cnt_q == last_cnt(state_q)) begin
            cnt_d = '0;
            if (state_q == S_EMG_CLEAR) begin
                state_d = resume_phase(saved_q);
            end else begin
                state_d = next_phase(state_q);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Lamp decode of the upcoming phase so the heads change on the same edge as the state.
    always_comb begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
        case (state_d)
            S_NS_LEFT:   ns_d = LAMP_LEFT;
            S_NS_GREEN:  ns_d = LAMP_GREEN;
            S_NS_YELLOW: ns_d = LAMP_YELLOW;
            S_EW_LEFT:   ew_d = LAMP_LEFT;
            S_EW_GREEN:  ew_d = LAMP_GREEN;
            S_EW_YELLOW: ew_d = LAMP_YELLOW;
            default: begin
                ns_d = LAMP_RED;
                ew_d = LAMP_RED;
            end
        endcase
        allstop_d = (state_d == S_ALLSTOP) || (state_d == S_EMG_CLEAR);
    end

    // State, counter, saved phase and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_NS_FIRST;
            saved_q <= S_NS_FIRST;
            cnt_q   <= '0;
            ns_out  <= LAMP_NS_RST;
            ew_out  <= LAMP_RED;
            allstop <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            ns_out  <= ns_d;
            ew_out  <= ew_d;
            allstop <= allstop_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_trafficlight_ctrl.sv
// Randomized bench for trafficlight_ctrl: three configurations run side by side,
// each compared every cycle against a phase-list reference model.
module tb_trafficlight_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] emg;
    logic [3:0] ns [3];
    logic [3:0] ew [3];
    logic [3:0] ph [3];
    logic [2:0] as_o;

    trafficlight_ctrl #(.LEFT_CYC(5), .GREEN_CYC(10), .YELLOW_CYC(3), .CLEAR_CYC(1),
                        .LEFT_EN(1), .CNT_W(5)) u_dut0 (
        .clk(clk), .reset(rst[0]), .emergency(emg[0]), .ns_out(ns[0]),
        .ew_out(ew[0]), .phase(ph[0]), .allstop(as_o[0]));
    trafficlight_ctrl #(.LEFT_CYC(5), .GREEN_CYC(10), .YELLOW_CYC(3), .CLEAR_CYC(4),
                        .LEFT_EN(1), .CNT_W(5)) u_dut1 (
        .clk(clk), .reset(rst[1]), .emergency(emg[1]), .ns_out(ns[1]),
        .ew_out(ew[1]), .phase(ph[1]), .allstop(as_o[1]));
    trafficlight_ctrl #(.LEFT_CYC(5), .GREEN_CYC(2), .YELLOW_CYC(1), .CLEAR_CYC(2),
                        .LEFT_EN(0), .CNT_W(5)) u_dut2 (
        .clk(clk), .reset(rst[2]), .emergency(emg[2]), .ns_out(ns[2]),
        .ew_out(ew[2]), .phase(ph[2]), .allstop(as_o[2]));

    int c_lft [3] = '{5, 5, 5};
    int c_grn [3] = '{10, 10, 2};
    int c_yel [3] = '{3, 3, 1};
    int c_clr [3] = '{1, 4, 2};
    int c_len [3] = '{1, 1, 0};

    // Model: position p in an 8-entry ring (p/4 = direction, p%4 = L,G,Y,C); mode 0 run, 1 allstop, 2 emg-clear.
    int m_mode [3];
    int m_p    [3];
    int m_t    [3];
    int m_sv   [3];
    bit m_chg  [3];
    logic [3:0] pv_ph [3];
    bit pv_ok [3] = '{1'b0, 1'b0, 1'b0};

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dur(input int k, input int p);
        case (p % 4)
            0:       return c_lft[k];
            1:       return c_grn[k];
            2:       return c_yel[k];
            default: return c_clr[k];
        endcase
    endfunction

    function automatic int adv(input int k, input int p);
        int q;
        q = (p + 1) % 8;
        if ((q % 4 == 0) && (c_len[k] == 0)) q = q + 1;
        return q;
    endfunction

    function automatic int first_ns(input int k);
        return (c_len[k] != 0) ? 0 : 1;
    endfunction

    function automatic int resume(input int k, input int p);
        if ((p % 4) <= 1) return p;
        return adv(k, p);
    endfunction

    task automatic model_step(input int k, input bit r, input bit e);
        int pm, pp;
        pm = m_mode[k];
        pp = m_p[k];
        if (r) begin
            m_mode[k] = 0; m_p[k] = first_ns(k); m_t[k] = 0; m_sv[k] = m_p[k];
        end else if (e && m_mode[k] != 1) begin
            if (m_mode[k] == 0) m_sv[k] = m_p[k];
            m_mode[k] = 1; m_t[k] = 0;
        end else if (m_mode[k] == 1) begin
            if (!e) begin m_mode[k] = 2; m_t[k] = 0; end
        end else if (m_mode[k] == 2) begin
            if (m_t[k] == c_clr[k] - 1) begin
                m_mode[k] = 0; m_p[k] = resume(k, m_sv[k]); m_t[k] = 0;
            end else m_t[k]++;
        end else begin
            if (m_t[k] == dur(k, m_p[k]) - 1) begin
                m_p[k] = adv(k, m_p[k]); m_t[k] = 0;
            end else m_t[k]++;
        end
        m_chg[k] = (pm != m_mode[k]) || ((m_mode[k] == 0) && (pp != m_p[k]));
    endtask

    task automatic check_dut(input int k);
        logic [3:0] lamp, e_ns, e_ew;
        e_ns = 4'b0001;
        e_ew = 4'b0001;
        if (m_mode[k] == 0 && (m_p[k] % 4) != 3) begin
            lamp = ((m_p[k] % 4) == 0) ? 4'b1001 : (((m_p[k] % 4) == 1) ? 4'b0100 : 4'b0010);
            if (m_p[k] < 4) e_ns = lamp; else e_ew = lamp;
        end
        check_eq($sformatf("d%0d ns", k), ns[k], e_ns);
        check_eq($sformatf("d%0d ew", k), ew[k], e_ew);
        check_eq($sformatf("d%0d allstop", k), as_o[k], (m_mode[k] != 0));
        check_eq($sformatf("d%0d safety", k), (ns[k] == 4'b0001) || (ew[k] == 4'b0001), 1'b1);
        check_eq($sformatf("d%0d onehot", k),
                 ($countones(ns[k][2:0]) == 1) && ($countones(ew[k][2:0]) == 1), 1'b1);
        if (pv_ok[k]) check_eq($sformatf("d%0d phase_chg", k), (ph[k] !== pv_ph[k]), m_chg[k]);
        pv_ph[k] = ph[k];
        pv_ok[k] = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, rst[k], emg[k]);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_for(input int k, input int md, input int p, input int t);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_mode[k] == md && (p < 0 || m_p[k] == p) && m_t[k] == t) hit = 1'b1;
            else cycle();
        end
        check_eq($sformatf("d%0d wait", k), hit, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_mode[k] = 0; m_p[k] = 0; m_t[k] = 0; m_sv[k] = 0; m_chg[k] = 1'b0;
        end
        rst = 3'b111;
        emg = 3'b000;
        @(negedge clk);
        run(3);
        rst = 3'b000;
        run(76);

        // NS_GREEN with counter at 6: four-cycle emergency, then full green
        wait_for(0, 0, 1, 6);
        emg[0] = 1'b1; run(4);
        emg[0] = 1'b0; run(16);

        // Single-cycle pulse during EW_YELLOW, counter 1
        wait_for(0, 0, 6, 1);
        emg[0] = 1'b1; run(1);
        emg[0] = 1'b0; run(6);

        // Re-assertion during a 4-cycle emergency clearance
        wait_for(1, 0, 5, 2);
        emg[1] = 1'b1; run(2);
        emg[1] = 1'b0; run(2);
        emg[1] = 1'b1; run(1);
        emg[1] = 1'b0; run(20);

        // Reset during ALLSTOP aborts without resume
        emg[2] = 1'b1; run(3);
        rst[2] = 1'b1; run(1);
        rst[2] = 1'b0; emg[2] = 1'b0; run(25);

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 9) == 0) emg[k] = ~emg[k];
                rst[k] = ($urandom_range(0, 149) == 0);
            end
            cycle();
        end
        emg = 3'b000;
        rst = 3'b000;
        run(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
